// File: rtl/fifo_umbral_pkg.sv
// rtl/fifo_umbral_pkg.sv - shared constants and error-state encoding for fifo_umbral
// Purpose: default word/address widths, default depth, and the sticky error
//          encoding that the control state machine also decodes.
// Ports:   none (package).
package fifo_umbral_pkg;

  localparam int BW_DEF    = 6;
  localparam int LEN_DEF   = 3;
  localparam int DEPTH_DEF = 2 ** LEN_DEF;

  // Sticky error register encoding; the control FSM relies on OK = 0.
  typedef enum logic {
    ERR_OK    = 1'b0,
    ERR_ERROR = 1'b1
  } err_state_e;

endpackage

// File: rtl/fifo_umbral_memoria_fifo.sv
// rtl/fifo_umbral_memoria_fifo.sv - register array with one write port and one registered read port
// Purpose: storage for fifo_umbral. The array itself is never reset; only the
//          read data register is cleared so data_out starts at zero.
// Ports:   clk, reset (sync, active-high), wr_en/wr_addr/wr_data (write port),
//          rd_en/rd_addr (read request), rd_data (registered read data).
module memoria_fifo
  import fifo_umbral_pkg::*;
#(
  parameter int BW  = BW_DEF,
  parameter int LEN = LEN_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [LEN-1:0] wr_addr,
  input  logic [BW-1:0]  wr_data,
  input  logic           rd_en,
  input  logic [LEN-1:0] rd_addr,
  output logic [BW-1:0]  rd_data
);

  logic [BW-1:0] mem_q [0:(2**LEN)-1];
  logic [BW-1:0] rd_data_d;
  logic [BW-1:0] rd_data_q;

  // Read and write on the same edge at the same address return the old word,
  // which is what a full FIFO needs on a simultaneous push/pop.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - synchronous FIFO with programmable almost-full/almost-empty thresholds
// Purpose: pointer, occupancy, flag and sticky error logic around memoria_fifo.
// Ports:   clk, reset (sync, active-high), data_in/push (write side),
//          pop/data_out/valid_out (read side, 1-cycle latency),
//          umbral_alto/umbral_bajo (thresholds in words), FifoFull, FifoEmpty,
//          almost_full, almost_empty, FifoError (sticky), count (occupancy).
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int BW  = BW_DEF,
  parameter int LEN = LEN_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] data_in,
  input  logic          push,
  input  logic          pop,
  input  logic [LEN:0]  umbral_alto,
  input  logic [LEN:0]  umbral_bajo,
  output logic [BW-1:0] data_out,
  output logic          valid_out,
  output logic          FifoFull,
  output logic          FifoEmpty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          FifoError,
  output logic [LEN:0]  count
);

  localparam logic [LEN:0]   DEPTH_C   = {1'b1, {LEN{1'b0}}};
  localparam logic [LEN:0]   CNT_ONE   = {{LEN{1'b0}}, 1'b1};
  localparam logic [LEN-1:0] PTR_ONE   = {{(LEN-1){1'b0}}, 1'b1};

  logic [LEN-1:0] wr_ptr_d, wr_ptr_q;
  logic [LEN-1:0] rd_ptr_d, rd_ptr_q;
  logic [LEN:0]   count_d, count_q;
  logic           valid_d, valid_q;
  err_state_e     err_d, err_q;

  logic full, empty;
  logic push_ok, pop_ok;

  // count alone decides full/empty; equal pointers are ambiguous.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A push into a full FIFO is still fine if a word leaves on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = pop_ok;
    err_d    = err_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end

    // Any rejected request is an overflow or underflow; latch until reset.
    if ((push && !push_ok) || (pop && !pop_ok)) begin
      err_d = ERR_ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  memoria_fifo #(
    .BW  (BW),
    .LEN (LEN)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign valid_out    = valid_q;
  assign FifoFull     = full;
  assign FifoEmpty    = empty;
  assign almost_full  = (count_q >= umbral_alto);
  assign almost_empty = (count_q <= umbral_bajo);
  assign FifoError    = (err_q == ERR_ERROR);
  assign count        = count_q;

endmodule
